obc_da_engine: RTL and testbench

OBC_DA_ENGINE -- requirements
Module: obc_da_engine

---
 rtl/obc_da_engine_if.sv | 41 ++++
 rtl/obc_da_engine.sv | 203 ++++++++++++++++++++
 tb/tb_obc_da_engine.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obc_da_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : obc_da_engine_if
//  Description : Bundles the streaming and configuration signals of the
//                offset-binary-coded distributed-arithmetic engine.
//                  master : producer/consumer/configuration side
//                  slave  : engine side
//  Signals     : in_valid/in_ready/in_data    sample vector handshake
//                out_valid/out_ready/out_data result handshake
//                cfg_we/cfg_addr/cfg_data     coefficient table writes
//  Revision    : 1.0  initial release
// ============================================================================
interface obc_da_engine_if #(
  parameter int PAIRS = 4,
  parameter int DW    = 16,
  parameter int CW    = 32
);
  localparam int RW = CW + DW + $clog2(PAIRS) + 1;
  localparam int AW = $clog2(2 * PAIRS) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [2*PAIRS*DW-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [RW-1:0]           out_data;
  logic                    cfg_we;
  logic [AW-1:0]           cfg_addr;
  logic [CW-1:0]           cfg_data;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/obc_da_engine.sv
`default_nettype none
// ============================================================================
//  Module      : obc_da_engine
//  Description : Bit-serial OBC distributed-arithmetic engine. Accepts
//                2*PAIRS two's-complement samples, walks their bits LSB
//                first (one bit per clock, DW clocks) and accumulates the
//                table entry picked by the XOR of each sample pair. The
//                sign bit's partial product is subtracted. An optional
//                offset register is added to the final result.
//  Ports       : clk   sole clock, rising edge
//                rst   synchronous active-high reset
//                bus   obc_da_engine_if.slave (data + config handshake)
//                busy  high whenever the engine is not idle
//  Options     : OBC_OFFSET_EN  when defined, address 2*PAIRS writes a CW-bit
//                               offset added to every result
//  Revision    : 1.0  initial release
// ============================================================================
module obc_da_engine #(
  parameter int PAIRS = 4,
  parameter int DW    = 16,
  parameter int CW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  obc_da_engine_if.slave   bus,
  output logic             busy
);

  localparam int RW   = CW + DW + $clog2(PAIRS) + 1;
  localparam int NE   = 2 * PAIRS;
  localparam int AW   = $clog2(NE) + 1;
  localparam int CNTW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_busy;

  logic [2*PAIRS*DW-1:0]   r_x;
  logic [CNTW-1:0]         r_cnt;
  logic [RW-1:0]           r_acc;
  logic [RW-1:0]           r_out;
  logic [CW-1:0]           r_tab [NE];

  logic [PAIRS-1:0]        w_sel;
  logic [CW-1:0]           w_entry [PAIRS];
  logic [RW-1:0]           w_p;
  logic [RW-1:0]           w_term;
  logic [RW-1:0]           w_acc_nxt;
  logic [RW-1:0]           w_off_ext;
  logic                    w_last;
  logic                    w_cfg_ok;

  assign w_last   = (r_cnt == CNTW'(DW - 1));
  // Configuration is only honoured while idle so a running sum never mixes
  // old and new coefficients.
  assign w_cfg_ok = (r_state == S_IDLE) && bus.cfg_we;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out;
  assign busy          = w_busy;

  // --------------------------------------------------------------------------
  // Per-pair table lookup: the XOR of the current bit of both samples in a
  // pair selects between the pair's two table entries.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < PAIRS; k++) begin : g_pair
    logic [DW-1:0] w_xa;
    logic [DW-1:0] w_xb;
    assign w_xa       = r_x[(2*k)*DW +: DW];
    assign w_xb       = r_x[(2*k+1)*DW +: DW];
    assign w_sel[k]   = w_xa[r_cnt] ^ w_xb[r_cnt];
    assign w_entry[k] = w_sel[k] ? r_tab[2*k+1] : r_tab[2*k];
  end

  // Partial product for this bit: sign-extended sum of the selected entries.
  always_comb begin
    w_p = '0;
    for (int k = 0; k < PAIRS; k++) begin
      w_p = w_p + {{(RW-CW){w_entry[k][CW-1]}}, w_entry[k]};
    end
  end

  // Weight by 2^bit; the sign bit of a two's-complement sample carries
  // negative weight, so its partial product is subtracted.
  assign w_term    = w_p << r_cnt;
  assign w_acc_nxt = w_last ? (r_acc - w_term) : (r_acc + w_term);

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x   <= bus.in_data;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          // The result register only changes on the final bit, so out_data
          // is stable for the whole DONE phase and an aborted run never
          // reaches it.
          if (w_last) begin
            r_out <= w_acc_nxt + w_off_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient table. A write in the same idle cycle as an input handshake
  // lands before the first SHIFT cycle reads it, so the new entry is used.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        r_tab[i] <= '0;
      end
    end else if (w_cfg_ok && (bus.cfg_addr < AW'(NE))) begin
      r_tab[bus.cfg_addr[AW-2:0]] <= bus.cfg_data;
    end
  end

`ifdef OBC_OFFSET_EN
  logic [CW-1:0] r_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_off <= '0;
    end else if (w_cfg_ok && (bus.cfg_addr == AW'(NE))) begin
      r_off <= bus.cfg_data;
    end
  end

  assign w_off_ext = {{(RW-CW){r_off[CW-1]}}, r_off};
`else
  assign w_off_ext = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obc_da_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obc_da_engine
//  Description : Directed self-checking bench for obc_da_engine with
//                PAIRS=4, DW=16, CW=32. Expected results are worked out by
//                hand from the DA sum definition.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_obc_da_engine;

  localparam int PAIRS = 4;
  localparam int DW    = 16;
  localparam int CW    = 32;
  localparam int RW    = CW + DW + $clog2(PAIRS) + 1;
  localparam int LAT   = DW + 1;

  logic clk;
  logic rst;
  logic busy;

  int n_checks;
  int n_errors;

  obc_da_engine_if #(.PAIRS(PAIRS), .DW(DW), .CW(CW)) bus ();

  obc_da_engine #(.PAIRS(PAIRS), .DW(DW), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [2*PAIRS*DW-1:0] mkvec(
    input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
    input logic [15:0] x3, input logic [15:0] x4, input logic [15:0] x5,
    input logic [15:0] x6, input logic [15:0] x7);
    return {x7, x6, x5, x4, x3, x2, x1, x0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic set_default_table();
    for (int k = 0; k < PAIRS; k++) begin
      cfg_write(4'(2*k), 32'd0);
      cfg_write(4'(2*k+1), 32'd1);
    end
  endtask

  // Drives one vector (optionally with a same-cycle config write), waits a
  // bounded time for out_valid and returns latency and data. lat is left at
  // the bound when the result never appears.
  task automatic send_vector(
    input  logic [2*PAIRS*DW-1:0] v,
    input  logic                  accept,
    input  logic                  do_cfg,
    input  logic [3:0]            a,
    input  logic [31:0]           d,
    output int                    lat,
    output logic [RW-1:0]         data);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    if (do_cfg) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_data = d;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    data = bus.out_data;
    if (accept && bus.out_valid) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [RW-1:0] data;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_errors++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    // Table cleared by reset: any vector sums to zero.
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== '0) begin
      n_errors++; $display("FAIL reset_table_zero: got %0h want 0", data);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [RW-1:0] data;
    logic signed [RW-1:0] exp_v;
    set_default_table();
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (lat !== LAT) begin
      n_errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (data !== RW'(1)) begin
      n_errors++; $display("FAIL basic_x0_1: got %0h want 1", data);
    end
    exp_v = -32768;
    send_vector(mkvec(16'h8000, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL basic_sign_bit: got %0h want %0h", data, exp_v);
    end
    send_vector(mkvec(16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== '0) begin
      n_errors++; $display("FAIL basic_pair_cancel: got %0h want 0", data);
    end
    // pair1 xor = 3, pair2 xor = 0x10 -> 3 + 16
    send_vector(mkvec(0, 0, 16'h0003, 0, 16'h0010, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== RW'(19)) begin
      n_errors++; $display("FAIL basic_multi_pair: got %0d want 19", data);
    end
  endtask

  task automatic test_table_values();
    int lat;
    logic [RW-1:0] data;
    logic signed [RW-1:0] exp_v;
    // T[0]=2, all bits select it: 2*(2^15-1) - 2*2^15 = -2
    cfg_write(4'd0, 32'd2);
    send_vector(mkvec(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    exp_v = -2;
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL table_even_entry: got %0h want %0h", data, exp_v);
    end
    cfg_write(4'd0, 32'd0);
    // T[1]=-3, x0=5 -> -15
    cfg_write(4'd1, 32'hFFFF_FFFD);
    send_vector(mkvec(16'h0005, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    exp_v = -15;
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL table_negative: got %0h want %0h", data, exp_v);
    end
    // Max positive entries on every pair, xor = 0x7FFF everywhere
    for (int k = 0; k < PAIRS; k++) cfg_write(4'(2*k+1), 32'h7FFF_FFFF);
    send_vector(mkvec(16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF, 0),
                1'b1, 1'b0, 0, 0, lat, data);
    exp_v = RW'(64'd4 * 64'd2147483647 * 64'd32767);
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL table_wide_sum: got %0h want %0h", data, exp_v);
    end
    set_default_table();
  endtask

  task automatic test_hold();
    int lat;
    logic [RW-1:0] data;
    int bad;
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL hold_busy: got %b want 1", busy);
    end
    // Hold the result and attempt a table write meanwhile
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd1;
    bus.cfg_data = 32'd9;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_data !== RW'(1) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    bus.cfg_we = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_release: got valid=%b ready=%b want valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== RW'(1)) begin
      n_errors++; $display("FAIL hold_write_dropped: got %0d want 1", data);
    end
  endtask

  task automatic test_cfg_in_shift();
    int lat;
    logic [RW-1:0] data;
    bus.in_valid = 1'b1;
    bus.in_data  = mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    cfg_write(4'd1, 32'd7);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    n_checks++;
    if (bus.out_data !== RW'(1) || bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL shift_write_current: got %0d valid=%b want 1 valid=1",
               bus.out_data, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== RW'(1)) begin
      n_errors++; $display("FAIL shift_write_next: got %0d want 1", data);
    end
  endtask

  task automatic test_same_cycle();
    int lat;
    logic [RW-1:0] data;
    // T[3]=10 written with the handshake; pair1 xor bit1 -> 10*2
    send_vector(mkvec(0, 0, 16'h0002, 0, 0, 0, 0, 0), 1'b1, 1'b1, 4'd3, 32'd10, lat, data);
    n_checks++;
    if (data !== RW'(20)) begin
      n_errors++; $display("FAIL same_cycle_write: got %0d want 20", data);
    end
    n_checks++;
    if (lat !== LAT) begin
      n_errors++; $display("FAIL same_cycle_latency: got %0d want %0d", lat, LAT);
    end
    cfg_write(4'd3, 32'd1);
  endtask

  task automatic test_addr_ignore();
    int lat;
    logic [RW-1:0] data;
    cfg_write(4'd9, 32'h0000_1000);
    cfg_write(4'd15, 32'h0000_2000);
    send_vector(mkvec(16'h0001, 0, 16'h0001, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== RW'(2)) begin
      n_errors++; $display("FAIL addr_ignore: got %0h want 2", data);
    end
  endtask

  task automatic test_offset();
    int lat;
    logic [RW-1:0] data;
    logic signed [RW-1:0] exp_v;
    cfg_write(4'd8, 32'd5);
    send_vector(mkvec(16'h0001, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
`ifdef OBC_OFFSET_EN
    exp_v = 6;
`else
    exp_v = 1;
`endif
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL offset_add: got %0d want %0d", data, exp_v);
    end
    send_vector(mkvec(16'h8000, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
`ifdef OBC_OFFSET_EN
    exp_v = -32763;
`else
    exp_v = -32768;
`endif
    n_checks++;
    if (data !== exp_v) begin
      n_errors++; $display("FAIL offset_negative: got %0h want %0h", data, exp_v);
    end
    cfg_write(4'd8, 32'd0);
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [RW-1:0] data;
    bus.in_valid = 1'b1;
    bus.in_data  = mkvec(16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_state: got valid=%b ready=%b busy=%b want 0 1 0",
               bus.out_valid, bus.in_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL reset_mid_discard: got %0d valid cycles want 0", seen);
    end
    set_default_table();
    send_vector(mkvec(16'h0003, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 0, 0, lat, data);
    n_checks++;
    if (data !== RW'(3) || lat !== LAT) begin
      n_errors++; $display("FAIL reset_mid_followup: got %0d lat %0d want 3 lat %0d",
                           data, lat, LAT);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    tick();
    test_reset();
    test_basic();
    test_table_values();
    test_hold();
    test_cfg_in_shift();
    test_same_cycle();
    test_addr_ignore();
    test_offset();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
